// File: rtl/list_builder_if.sv
// Handshake and RAM-write bundle for the list builder.
// master: element producer and RAM/status consumer; slave: the builder.
interface list_builder_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] head_addr;
  logic [AW-1:0] count;
  logic          overflow;
  logic          done;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  head_addr, count, overflow, done
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output head_addr, count, overflow, done
  );
endinterface

// File: rtl/list_builder_fsm.sv
// Writes a value stream into list RAM as {value, next} node pairs, null-terminated.
// Ports: clk, rst (sync, active-high), bus (list_builder_if.slave).
module list_builder_fsm #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int BASE_ADDR = 2
) (
  input  logic           clk,
  input  logic           rst,
  list_builder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    WRITE_VAL,
    WRITE_NEXT,
    DONE
  } state_t;

  localparam int            CAP   = ((1 << AW) - BASE_ADDR) / 2;
  localparam logic [AW-1:0] BASE  = AW'(BASE_ADDR);
  localparam logic [AW-1:0] CAP_W = AW'(CAP);

  state_t        state, nxt;
  logic [AW-1:0] ptr;
  logic [AW-1:0] count;
  logic [DW-1:0] data;
  logic          last;
  logic          overflow;

  logic [AW-1:0] ptr1;
  logic [AW-1:0] ptr2;
  logic          full;

  assign ptr1 = ptr + AW'(1);
  assign ptr2 = ptr + AW'(2);
  // This node fills the last free slot; CAP keeps ptr+1 from wrapping.
  assign full = (count + AW'(1)) == CAP_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= BASE;
      count    <= '0;
      data     <= '0;
      last     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            ptr      <= BASE;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        WAIT_DATA: begin
          if (bus.in_valid) begin
            data <= bus.in_data;
            last <= bus.in_last;
          end
        end
        WRITE_NEXT: begin
          count <= count + AW'(1);
          if (!last) begin
            if (full) overflow <= 1'b1;
            else      ptr      <= ptr2;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt           = state;
    bus.in_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) nxt = WRITE_VAL;
      end
      WRITE_VAL: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = ptr;
        bus.mem_wdata = data;
        nxt           = WRITE_NEXT;
      end
      WRITE_NEXT: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = ptr1;
        if (last || full) begin
          nxt = DONE;
        end else begin
          bus.mem_wdata = DW'(ptr2);
          nxt           = WAIT_DATA;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        // Held start must not rebuild; require a low phase first.
        if (!bus.start) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.head_addr = BASE;
  assign bus.count     = count;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_list_builder_fsm.sv
// Randomized bench for list_builder_fsm against a node-list model.
// Two instances: AW=8 (CAP=127) and AW=3 (CAP=3).
module tb_list_builder_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  list_builder_if #(.DW(8), .AW(8)) b0 ();
  list_builder_if #(.DW(8), .AW(3)) b1 ();

  list_builder_fsm #(.DW(8), .AW(8), .BASE_ADDR(2)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  list_builder_fsm #(.DW(8), .AW(3), .BASE_ADDR(2)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {int a; int d;} wr_t;
  wr_t wq0[$];
  wr_t wq1[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (b0.mem_we) wq0.push_back('{a: int'(b0.mem_addr), d: int'(b0.mem_wdata)});
      if (b1.mem_we) wq1.push_back('{a: int'(b1.mem_addr), d: int'(b1.mem_wdata)});
      if (b0.in_ready || b0.mem_we || b0.done)
        chk("excl0", {b0.in_ready, b0.mem_we, b0.done} inside {3'b100, 3'b010, 3'b001}, 1);
      if (b1.in_ready || b1.mem_we || b1.done)
        chk("excl1", {b1.in_ready, b1.mem_we, b1.done} inside {3'b100, 3'b010, 3'b001}, 1);
    end
  end

  task automatic drv(input bit s, input bit v, input logic [7:0] d, input bit l);
    if (s) begin
      b1.in_valid = v; b1.in_data = d; b1.in_last = l;
    end else begin
      b0.in_valid = v; b0.in_data = d; b0.in_last = l;
    end
  endtask

  task automatic set_start(input bit s, input bit v);
    if (s) b1.start = v;
    else   b0.start = v;
  endtask

  function automatic bit f_rdy(input bit s);
    return s ? b1.in_ready : b0.in_ready;
  endfunction
  function automatic bit f_done(input bit s);
    return s ? b1.done : b0.done;
  endfunction
  function automatic bit f_ovf(input bit s);
    return s ? b1.overflow : b0.overflow;
  endfunction
  function automatic int f_cnt(input bit s);
    return s ? int'(b1.count) : int'(b0.count);
  endfunction
  function automatic int f_nwr(input bit s);
    return s ? wq1.size() : wq0.size();
  endfunction

  task automatic send(input bit s, input logic [7:0] d, input bit l,
                      input int lim, output bit ok);
    bit acc;
    ok = 0;
    drv(s, 1'b1, d, l);
    for (int n = 0; n < lim; n++) begin
      acc = f_rdy(s);
      @(negedge clk);
      if (acc) begin
        ok = 1;
        break;
      end
    end
    drv(s, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_done(input bit s);
    for (int n = 0; n < 30; n++) begin
      if (f_done(s)) break;
      @(negedge clk);
    end
    chk("done_seen", f_done(s), 1);
  endtask

  task automatic run_list(input bit s, input int vals[$], input bit use_last,
                          input int cap, input int maxgap, input bit hold);
    wr_t exp[$];
    wr_t got[$];
    int  n, m, nw;
    bit  ok, l, term, ovf;
    n = vals.size();
    m = (n < cap) ? n : cap;
    if (s) wq1.delete();
    else   wq0.delete();
    set_start(s, 1'b1);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      l = use_last && (i == n - 1);
      send(s, vals[i][7:0], l, (i < m) ? 40 : 10, ok);
      chk($sformatf("acc%0d", i), ok, (i < m) ? 1 : 0);
    end
    wait_done(s);
    for (int i = 0; i < m; i++) begin
      term = (use_last && i == n - 1) || (i == cap - 1);
      exp.push_back('{a: 2 + 2 * i, d: vals[i] & 255});
      exp.push_back('{a: 3 + 2 * i, d: term ? 0 : 4 + 2 * i});
    end
    ovf = (m == cap) && !(use_last && n == cap);
    got = s ? wq1 : wq0;
    chk("nwr", got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("wa%0d", i), got[i].a, exp[i].a);
      chk($sformatf("wd%0d", i), got[i].d, exp[i].d);
    end
    chk("count", f_cnt(s), m);
    chk("ovf", f_ovf(s), ovf);
    if (hold) begin
      nw = f_nwr(s);
      repeat (8) @(negedge clk);
      chk("hold_done", f_done(s), 1);
      chk("hold_nwr", f_nwr(s), nw);
      chk("hold_rdy", f_rdy(s), 0);
    end
    set_start(s, 1'b0);
    @(negedge clk);
    chk("done_drop", f_done(s), 0);
    chk("cnt_hold", f_cnt(s), m);
    chk("ovf_hold", f_ovf(s), ovf);
  endtask

  initial begin
    int  q[$];
    int  n;
    bit  ok, ul;
    drv(0, 0, 0, 0);
    drv(1, 0, 0, 0);
    set_start(0, 0);
    set_start(1, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy", b0.in_ready, 0);
    chk("rst_we", b0.mem_we, 0);
    chk("rst_done", b0.done, 0);
    chk("rst_ovf", b0.overflow, 0);
    chk("rst_addr", b0.mem_addr, 0);
    chk("rst_wdata", b0.mem_wdata, 0);
    chk("rst_cnt", b0.count, 0);
    chk("head", b0.head_addr, 2);
    rst = 1'b0;
    @(negedge clk);

    q = '{5, 7, 9};
    run_list(0, q, 1, 127, 0, 0);
    q = '{42};
    run_list(0, q, 1, 127, 0, 0);
    q = '{1, 2, 3, 4};
    run_list(1, q, 0, 3, 0, 0);
    q = '{5, 7, 9};
    run_list(0, q, 1, 127, 4, 0);

    set_start(0, 1);
    @(negedge clk);
    send(0, 8'd5, 0, 40, ok);
    chk("r_acc0", ok, 1);
    send(0, 8'd7, 0, 40, ok);
    chk("r_acc1", ok, 1);
    for (int i = 0; i < 10; i++) begin
      if (b0.mem_we && b0.mem_addr == 8'd5) break;
      @(negedge clk);
    end
    chk("r_hit", b0.mem_we && b0.mem_addr == 8'd5, 1);
    rst = 1'b1;
    set_start(0, 0);
    @(negedge clk);
    chk("r_we", b0.mem_we, 0);
    chk("r_cnt", b0.count, 0);
    chk("r_rdy", b0.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("r_idle", b0.in_ready, 0);
    q = '{3, 4};
    run_list(0, q, 1, 127, 1, 0);

    q = '{1, 2};
    run_list(0, q, 1, 127, 2, 1);
    q = '{8};
    run_list(0, q, 1, 127, 0, 0);
    q = '{9, 10};
    run_list(1, q, 1, 3, 1, 0);

    for (int it = 0; it < 15; it++) begin
      q.delete();
      n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(255, 0)));
      run_list(0, q, 1, 127, 3, $urandom_range(1, 0) == 1);
    end
    for (int it = 0; it < 10; it++) begin
      q.delete();
      n = $urandom_range(5, 1);
      for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(255, 0)));
      ul = (n < 3) ? 1'b1 : ($urandom_range(1, 0) == 1);
      run_list(1, q, ul, 3, 2, $urandom_range(1, 0) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
